// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
// Build option CLKDIV_SYNC_EN is consumed by clk_divider_prog.
package clkdiv_pkg;

    localparam int CNT_WIDTH_DFLT = 16;
    localparam int DIV_STOP       = 0;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/clk_divider_prog.sv
// Programmable 50%-duty clock divider with rising-edge tick strobe.
// Define CLKDIV_SYNC_EN to add the sync_in phase-alignment input.
module clk_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DFLT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_WIDTH-1:0] div_in,
    input  logic                 div_load,
`ifdef CLKDIV_SYNC_EN
    input  logic                 sync_in,
`endif
    output logic                 busy,
    output logic                 load_ack,
    output logic                 clk_out,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] div_cur
);

    localparam logic [CNT_WIDTH-1:0] DIV_RST  = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] DIV_ZERO = CNT_WIDTH'(DIV_STOP);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam state_e ST_RST = (DEFAULT_DIV != 0) ? RUN : STOP;

    state_e               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_div_cur;
    logic [CNT_WIDTH-1:0] r_pend;
    logic                 r_busy;
    logic                 r_ack;
    logic                 r_clk;
    logic                 r_tick;

    logic [CNT_WIDTH-1:0] w_last;
    logic                 w_wrap;
    logic                 w_sync;
    logic                 w_bound;
    logic                 w_apply;
    logic                 w_to_stop;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    // div_cur is never 0 in RUN, so div_cur-1 cannot wrap here
    assign w_last    = r_div_cur - ONE;
    assign w_wrap    = (r_cnt == w_last);
    assign w_bound   = w_sync | (w_wrap & r_clk);
    assign w_apply   = w_bound & r_busy;
    assign w_to_stop = w_apply & (r_pend == DIV_ZERO);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RST;
            r_cnt     <= '0;
            r_div_cur <= DIV_RST;
            r_pend    <= '0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_tick <= 1'b0;
            unique case (r_state)
                STOP: begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (r_busy) begin
                        r_div_cur <= r_pend;
                        r_ack     <= 1'b1;
                        r_busy    <= 1'b0;
                        if (r_pend != DIV_ZERO) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_sync || w_wrap) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                    if (w_apply) begin
                        r_div_cur <= r_pend;
                        r_ack     <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                    // sync pulse forces a rising edge unless the divider stops
                    if (w_to_stop) begin
                        r_state <= STOP;
                        r_clk   <= 1'b0;
                    end else if (w_sync) begin
                        r_clk  <= 1'b1;
                        r_tick <= 1'b1;
                    end else if (w_wrap) begin
                        r_clk  <= ~r_clk;
                        r_tick <= ~r_clk;
                    end
                end
                default: r_state <= STOP;
            endcase
            // a fresh load overrides the busy clear of a same-cycle apply
            if (div_load) begin
                r_pend <= div_in;
                r_busy <= 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign load_ack = r_ack;
    assign clk_out  = r_clk;
    assign tick     = r_tick;
    assign div_cur  = r_div_cur;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: directed loads, stop, reset, sync.
// Per-cycle expectations are queued by stimulus and popped by a monitor.
module tb_clk_divider_prog;

    localparam int W = 16;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in   = '0;
`ifdef CLKDIV_SYNC_EN
    logic         sync_in  = 1'b0;
`endif
    logic         busy;
    logic         load_ack;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_cur;

    typedef struct {
        int    cyc;
        string nm;
        bit    c;
        bit    t;
        bit    b;
        bit    a;
        int    d;
    } exp_t;

    exp_t q[$];
    int cyc       = 0;
    int errors    = 0;
    int checks    = 0;
    int acks      = 0;
    int exp_acks  = 0;

    clk_divider_prog #(
        .CNT_WIDTH  (W),
        .DEFAULT_DIV(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .div_in  (div_in),
        .div_load(div_load),
`ifdef CLKDIV_SYNC_EN
        .sync_in (sync_in),
`endif
        .busy    (busy),
        .load_ack(load_ack),
        .clk_out (clk_out),
        .tick    (tick),
        .div_cur (div_cur)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ex(input int c, input string nm, input bit co,
                      input bit t, input bit b, input bit a, input int d);
        exp_t e;
        e.cyc = c;
        e.nm  = nm;
        e.c   = co;
        e.t   = t;
        e.b   = b;
        e.a   = a;
        e.d   = d;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        div_in   = W'(v);
        div_load = 1'b1;
    endtask

    // Monitor: outputs sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (load_ack) acks++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: expectation missed at cyc %0d",
                             e.nm, e.cyc, cyc);
                end else if ({clk_out, tick, busy, load_ack} !=
                             {e.c, e.t, e.b, e.a} || div_cur != W'(e.d)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got clk_out=%b tick=%b busy=%b ack=%b div=%0d, want %b %b %b %b %0d",
                             e.nm, cyc, clk_out, tick, busy, load_ack, div_cur,
                             e.c, e.t, e.b, e.a, e.d);
                end
            end
        end
    end

    initial begin
        int b;
        // reset state, then legacy divide-by-4
        step(2);
        b = cyc;
        ex(b + 1, "rst", 0, 0, 0, 0, 2);
        step(1);
        reset = 1'b0;
        b = cyc;
        for (int n = 1; n <= 16; n++)
            ex(b + n, "div2", (n % 4) >= 2, (n % 4) == 2, 0, 0, 2);
        step(16);

        // load 3, then load 5 mid-high-phase
        b = cyc;
        ex(b + 1, "ld3", 0, 0, 1, 0, 2);
        ex(b + 2, "ld3", 1, 1, 1, 0, 2);
        ex(b + 3, "ld3", 1, 0, 1, 0, 2);
        ex(b + 4, "ld3", 0, 0, 0, 1, 3);
        ex(b + 5, "div3", 0, 0, 0, 0, 3);
        ex(b + 6, "div3", 0, 0, 0, 0, 3);
        ex(b + 7, "div3", 1, 1, 0, 0, 3);
        ex(b + 8, "div3", 1, 0, 0, 0, 3);
        ex(b + 9, "ld5", 1, 0, 1, 0, 3);
        ex(b + 10, "ld5", 0, 0, 0, 1, 5);
        for (int n = 11; n <= 14; n++) ex(b + n, "div5lo", 0, 0, 0, 0, 5);
        ex(b + 15, "div5", 1, 1, 0, 0, 5);
        for (int n = 16; n <= 19; n++) ex(b + n, "div5hi", 1, 0, 0, 0, 5);
        ex(b + 20, "div5", 0, 0, 0, 0, 5);
        exp_acks += 2;
        load(3);
        step(1);
        div_load = 1'b0;
        step(7);
        load(5);
        step(1);
        div_load = 1'b0;
        step(11);

        // load 4, then 0 to stop, then restart with 1
        b = cyc;
        for (int n = 1; n <= 4; n++) ex(b + n, "ld4", 0, 0, 1, 0, 5);
        ex(b + 5, "ld4", 1, 1, 1, 0, 5);
        for (int n = 6; n <= 9; n++) ex(b + n, "ld4", 1, 0, 1, 0, 5);
        ex(b + 10, "ld4", 0, 0, 0, 1, 4);
        for (int n = 11; n <= 13; n++) ex(b + n, "div4", 0, 0, 0, 0, 4);
        ex(b + 14, "div4", 1, 1, 0, 0, 4);
        ex(b + 15, "div4", 1, 0, 0, 0, 4);
        ex(b + 16, "ld0", 1, 0, 1, 0, 4);
        ex(b + 17, "ld0", 1, 0, 1, 0, 4);
        ex(b + 18, "ld0", 0, 0, 0, 1, 0);
        for (int n = 19; n <= 24; n++) ex(b + n, "stop", 0, 0, 0, 0, 0);
        ex(b + 25, "ld1", 0, 0, 1, 0, 0);
        ex(b + 26, "ld1", 0, 0, 0, 1, 1);
        for (int n = 27; n <= 32; n++)
            ex(b + n, "div1", (n % 2) == 1, (n % 2) == 1, 0, 0, 1);
        exp_acks += 3;
        load(4);
        step(1);
        div_load = 1'b0;
        step(14);
        load(0);
        step(1);
        div_load = 1'b0;
        step(8);
        load(1);
        step(1);
        div_load = 1'b0;
        step(7);

        // load held across a boundary: 7 applied while 9 becomes pending
        b = cyc;
        ex(b + 1, "ovl", 1, 1, 1, 0, 1);
        ex(b + 2, "ovl", 0, 0, 1, 1, 7);
        for (int n = 3; n <= 8; n++) ex(b + n, "div7", 0, 0, 1, 0, 7);
        ex(b + 9, "div7", 1, 1, 1, 0, 7);
        for (int n = 10; n <= 15; n++) ex(b + n, "div7", 1, 0, 1, 0, 7);
        ex(b + 16, "ap9", 0, 0, 0, 1, 9);
        // two loads before one boundary: last write wins
        b = b + 16;
        ex(b + 1, "two", 0, 0, 0, 0, 9);
        ex(b + 2, "two", 0, 0, 0, 0, 9);
        for (int n = 3; n <= 8; n++) ex(b + n, "two", 0, 0, 1, 0, 9);
        ex(b + 9, "two", 1, 1, 1, 0, 9);
        for (int n = 10; n <= 17; n++) ex(b + n, "two", 1, 0, 1, 0, 9);
        ex(b + 18, "two_ack", 0, 0, 0, 1, 9);
        ex(b + 19, "two", 0, 0, 0, 0, 9);
        ex(b + 20, "two", 0, 0, 0, 0, 9);
        exp_acks += 3;
        load(7);
        step(1);
        div_in = W'(9);
        step(1);
        div_load = 1'b0;
        step(14);
        step(2);
        load(7);
        step(1);
        div_load = 1'b0;
        step(2);
        load(9);
        step(1);
        div_load = 1'b0;
        step(14);

        // reset mid-high-phase with a load pending
        b = cyc;
        for (int n = 1; n <= 6; n++) ex(b + n, "pre", 0, 0, 0, 0, 9);
        ex(b + 7, "pre", 1, 1, 0, 0, 9);
        ex(b + 8, "pre", 1, 0, 0, 0, 9);
        ex(b + 9, "pend", 1, 0, 1, 0, 9);
        ex(b + 10, "mrst", 0, 0, 0, 0, 2);
        ex(b + 11, "post", 0, 0, 0, 0, 2);
        ex(b + 12, "post", 1, 1, 0, 0, 2);
        ex(b + 13, "post", 1, 0, 0, 0, 2);
        ex(b + 14, "post", 0, 0, 0, 0, 2);
        ex(b + 15, "post", 0, 0, 0, 0, 2);
        ex(b + 16, "post", 1, 1, 0, 0, 2);
        step(8);
        load(3);
        step(1);
        div_load = 1'b0;
        reset    = 1'b1;
        step(1);
        reset    = 1'b0;
        step(6);

`ifdef CLKDIV_SYNC_EN
        // sync pulse at cnt=2 of the low phase at DIV=4
        b = cyc;
        ex(b + 1, "s_ld", 1, 0, 1, 0, 2);
        ex(b + 2, "s_ld", 0, 0, 0, 1, 4);
        ex(b + 3, "s_lo", 0, 0, 0, 0, 4);
        ex(b + 4, "s_lo", 0, 0, 0, 0, 4);
        ex(b + 5, "sync", 1, 1, 0, 0, 4);
        for (int n = 6; n <= 8; n++) ex(b + n, "s_hi", 1, 0, 0, 0, 4);
        ex(b + 9, "s_fall", 0, 0, 0, 0, 4);
        exp_acks += 1;
        load(4);
        step(1);
        div_load = 1'b0;
        step(3);
        sync_in = 1'b1;
        step(1);
        sync_in = 1'b0;
        step(5);
`endif

        step(2);
        checks++;
        if (acks != exp_acks || q.size() != 0) begin
            errors++;
            $display("FAIL ack_count: got %0d acks (%0d left queued), want %0d acks",
                     acks, q.size(), exp_acks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
